// File: rtl/md_unit.sv
// Iterative multiply/divide unit for the EX stage.
// MULT/MULTU use radix-2 shift-add, DIV/DIVU use restoring shift-subtract on
// operand magnitudes; signs are re-applied in a final FIX cycle that commits
// the result into the architectural HI/LO registers. MTHI/MTLO write HI/LO
// directly from busA without leaving IDLE.
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;      // negate product / quotient
    logic                 rneg_q, rneg_d;    // negate remainder
    logic                 dz_q, dz_d;        // divide by zero
    logic [WIDTH-1:0]     opa_q, opa_d;      // raw dividend, returned on divide by zero
    logic [WIDTH-1:0]     opb_q, opb_d;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   acc_q, acc_d;      // {partial hi, multiplier} or {remainder, quotient}
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 signed_op;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       rem_diff;
    logic [2*WIDTH-1:0]   result;

    // Absolute value of a WIDTH-bit operand when it is treated as signed.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        logic signed [WIDTH-1:0] xs;
        xs = x;
        if (sgn && xs[WIDTH-1]) begin
            xs = -xs;
        end
        return xs;
    endfunction

    // Conditional two's-complement negation, WIDTH bits.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic n);
        logic signed [WIDTH-1:0] xs;
        xs = x;
        if (n) begin
            xs = -xs;
        end
        return xs;
    endfunction

    // Conditional two's-complement negation, 2*WIDTH bits.
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x, input logic n);
        logic signed [2*WIDTH-1:0] xs;
        xs = x;
        if (n) begin
            xs = -xs;
        end
        return xs;
    endfunction

    assign signed_op = ~md_op[0];
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    assign rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
    assign rem_diff  = rem_sh - {1'b0, opb_q};

    // Sign-corrected {hi, lo} value committed in FIX.
    always_comb begin
        result = neg_2w(acc_q, neg_q);
        if (is_div_q) begin
            if (dz_q) begin
                result = {opa_q, {WIDTH{1'b1}}};
            end else begin
                result = {neg_w(acc_q[2*WIDTH-1:WIDTH], rneg_q),
                          neg_w(acc_q[WIDTH-1:0], neg_q)};
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush always returns to IDLE and beats start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!flush && start && !md_op[2]) state_d = CALC;
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: operand latch, one iteration step, commit.
    always_comb begin
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!flush && start) begin
                    case (md_op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            is_div_d = md_op[1];
                            neg_d    = signed_op & (busA[WIDTH-1] ^ busB[WIDTH-1]);
                            rneg_d   = signed_op & busA[WIDTH-1];
                            dz_d     = md_op[1] && (busB == '0);
                            opa_d    = busA;
                            opb_d    = mag(busB, signed_op);
                            acc_d    = {{WIDTH{1'b0}}, mag(busA, signed_op)};
                            cnt_d    = '0;
                        end
                        3'b100: begin
                            hi_d   = busA;
                            done_d = 1'b1;
                        end
                        3'b101: begin
                            lo_d   = busA;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (flush) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (!is_div_q) begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end else if (rem_diff[WIDTH]) begin
                        acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end
                end
            end
            FIX: begin
                cnt_d = '0;
                if (!flush) begin
                    {hi_d, lo_d} = result;
                    done_d       = 1'b1;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Datapath and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // Outputs.
    always_comb begin
        busy = (state_q != IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized ops checked
// against an arithmetic reference model of HI/LO.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  md_op = 3'b000;
    logic [31:0] busA = '0;
    logic [31:0] busB = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int miscompares = 0;

    // Architectural HI/LO as the model expects them.
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    md_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
        .busA(busA), .busB(busB), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result {hi, lo} from plain arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin
                q = sa * sb;
                return q;
            end
            3'd1: begin
                p = ua * ub;
                return p;
            end
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                p = ua / ub;
                ua = ua % ub;
                return {ua[31:0], p[31:0]};
            end
        endcase
    endfunction

    // Issue a multi-cycle op and check latency, busy window and result.
    // inj_at >= 0 pulses a second start with inj_op at that cycle of the op.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string tag,
                          input int inj_at, input logic [2:0] inj_op);
        int n;
        int busy_cnt;
        start = 1'b1; md_op = op; busA = a; busB = b;
        tick();
        start = 1'b0; busA = $urandom; busB = $urandom;
        n = 0;
        busy_cnt = 0;
        while (!done && n < 100) begin
            if (busy) busy_cnt++;
            if (n == inj_at) begin
                start = 1'b1; md_op = inj_op; busA = 32'h0BAD_F00D; busB = 32'd3;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check({tag, " latency"}, n, 33);
        check({tag, " busy_cycles"}, busy_cnt, 33);
        check({tag, " hi_lo"}, {hi, lo}, {eh, el});
        check({tag, " busy_at_done"}, busy, 1'b0);
        tick();
        check({tag, " done_pulse"}, {busy, done}, 2'b00);
        exp_hi = eh;
        exp_lo = el;
    endtask

    // Single-cycle IDLE ops: MTHI, MTLO, and the reserved codes.
    task automatic idle_op(input logic [2:0] op, input logic [31:0] a, input string tag);
        logic exp_done;
        start = 1'b1; md_op = op; busA = a; busB = $urandom;
        tick();
        start = 1'b0;
        exp_done = 1'b0;
        if (op == 3'b100) begin exp_hi = a; exp_done = 1'b1; end
        if (op == 3'b101) begin exp_lo = a; exp_done = 1'b1; end
        check({tag, " state"}, {busy, done}, {1'b0, exp_done});
        check({tag, " hi_lo"}, {hi, lo}, {exp_hi, exp_lo});
        tick();
        check({tag, " done_clear"}, done, 1'b0);
    endtask

    initial begin
        int dcnt;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [63:0] r;

        // Reset state
        tick();
        tick();
        check("reset", {busy, done, hi, lo}, 66'd0);
        rst_n = 1'b1;
        tick();

        // Directed arithmetic cases
        run_op(3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg", -1, 3'b000);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", -1, 3'b000);
        run_op(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7", -1, 3'b000);
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2", -1, 3'b000);
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf", -1, 3'b000);
        run_op(3'b011, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, "divu_zero", -1, 3'b000);
        run_op(3'b010, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, "div_zero", -1, 3'b000);

        // MTHI then flushed DIVU: no commit, no done
        idle_op(3'b100, 32'hA5A5_A5A5, "mthi");
        start = 1'b1; md_op = 3'b011; busA = 32'd9; busB = 32'd2;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush state", {busy, done}, 2'b00);
        check("flush hi_lo", {hi, lo}, {32'hA5A5_A5A5, exp_lo});
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) dcnt++;
            tick();
        end
        check("flush quiet", dcnt, 0);

        // Flush in IDLE beats start
        flush = 1'b1; start = 1'b1; md_op = 3'b101; busA = 32'h1357_9BDF;
        tick();
        flush = 1'b0; start = 1'b0;
        check("idle_flush", {busy, done, lo}, {2'b00, exp_lo});

        // Starts during busy and in the FIX cycle are ignored
        run_op(3'b000, 32'd7, 32'd9, 32'd0, 32'd63, "start_busy", 5, 3'b011);
        run_op(3'b001, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, "start_fix", 32, 3'b100);

        // Reserved op codes do nothing
        idle_op(3'b110, 32'hDEAD_BEEF, "op110");
        idle_op(3'b111, 32'hCAFE_F00D, "op111");

        // Asynchronous reset mid-CALC
        start = 1'b1; md_op = 3'b001; busA = 32'hFFFF_0000; busB = 32'h1234_5678;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        #1;
        check("async_reset", {busy, done, hi, lo}, 66'd0);
        tick();
        rst_n = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) dcnt++;
            tick();
        end
        check("reset quiet", {dcnt, hi, lo}, {32'd0, 64'd0});

        // Randomized ops against the model
        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = 32'($urandom_range(1, 17));
                2: b = -32'($urandom_range(1, 17));
                default: ;
            endcase
            if (op < 3'd4) begin
                r = model(op, a, b);
                run_op(op, a, b, r[63:32], r[31:0], $sformatf("rand%0d_op%0d", k, op), -1, 3'b000);
            end else begin
                idle_op(op, a, $sformatf("rand%0d_op%0d", k, op));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
